karatsuba_gf2_mult_seq: RTL and testbench
=========================================

Name: karatsuba_gf2_mult_seq

Overview:
Parametrised, multi-cycle Karatsuba carry-less (GF(2)[x]) multiplier with a valid/ready handshake on input and output.
It computes the full (2M-1)-bit polynomial product, or optionally that product reduced modulo an irreducible polynomial to give a GF(2^M) field product.
It time-shares one P-bit combinational carry-less sub-multiplier over three cycles, one per Karatsuba partial product.
It sits in front of field-arithmetic datapaths (CRC/GHASH/AES-style consumers) that need a compact, area-lean multiplier.

Parameters:
M, 8, operand width in bits; legal range 2..64.
POLY, 9'h11B, (M+1)-bit reduction polynomial; bit M must be 1; used only when reduction is selected.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands and mode are presented.
in_ready  out  1  block can accept operands.
in_a  in  M  operand A, polynomial coefficients, bit 0 = x^0.
in_b  in  M  operand B.
in_reduce  in  1  1 = reduce the result mod POLY; 0 = raw product.
out_valid  out  1  result is available.
out_ready  in  1  consumer accepts the result.
out_data  out  2M-1  result; in reduce mode bits [2M-2:M] are 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_data=0, all internal registers cleared.
- Split: P=ceil(M/2). A_l=A[P-1:0]; A_h=A[M-1:P], zero-extended to P bits when M is odd. B is split the same way. All additions are XOR; there are no carries anywhere.
- States: IDLE -> LL -> HH -> MID -> COMB -> RED -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid&&in_ready, latch in_a, in_b, in_reduce and go to LL. Operand changes after the handshake have no effect.
- LL: sub-multiplier computes A_l*B_l; the result is registered as C_ll (2P-1 bits).
- HH: computes A_h*B_h into C_hh.
- MID: computes (A_l^A_h)*(B_l^B_h) into C_m.
- COMB: raw = (C_hh<<2P) ^ ((C_m^C_hh^C_ll)<<P) ^ C_ll, truncated to 2M-1 bits. For any legal input, all bits above 2M-2 are 0.
- RED: if the latched reduce bit is 1, reduce raw mod POLY. Do this by scanning bits 2M-2 down to M in one combinational pass; for each set bit i, XOR in POLY<<(i-M). The result has bits [2M-2:M]=0. If the reduce bit is 0, raw passes through unchanged. The result is registered into out_data.
- DONE: out_valid=1. out_data is held stable while out_ready=0. When out_valid&&out_ready, go to IDLE, and out_valid=0 next cycle. out_data keeps its last value; consumers ignore it while out_valid=0.
- Latency: the handshake occurs in cycle 0 and out_valid=1 in cycle 6. The latency is fixed and independent of mode and M.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored and nothing is queued. A new handshake is possible at the earliest in the cycle after the output handshake, giving a maximum throughput of 1 result per 7 cycles.
- The sub-multiplier is a combinational schoolbook AND/XOR array of P bits by P bits. There is a single instance; no other multipliers are inferred.
- rst_n asserted mid-operation (any state): abort immediately, return to the reset values, and produce no partial result.
- in_reduce=1 with M-bit operands is always legal. POLY is not required to be irreducible; the block computes the remainder either way.

Test Plan:
- M=8, in_a=8'h57, in_b=8'h83, in_reduce=0 -> out_data=15'h2B79, out_valid exactly 6 cycles after the handshake.
- M=8, same operands, in_reduce=1, POLY=9'h11B -> out_data=15'h00C1. Then in_a=8'h01, in_b=8'hAB, in_reduce=1 -> 15'h00AB. Then in_a=8'h00, in_b=8'hAB -> 15'h0000.
- M=5 (odd split, P=3), in_a=5'h1F, in_b=5'h1F, in_reduce=0 -> out_data=9'h155. M=8, 8'hFF*8'hFF raw -> 15'h5555.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data is constant, in_ready=0, and a second in_valid is not accepted. Raise out_ready -> in_ready=1 on the next cycle and the second transaction completes correctly.
- Reset mid-op: deassert rst_n during MID -> out_valid=0 and in_ready=1 asynchronously. After release, a fresh 8'h57*8'h83 reduce transaction gives 15'h00C1.
- Random regression, M in {2,5,8,16,33}, 10k transactions each with random out_ready stalls -> matches the bench reference (bitwise shift/XOR product, then mod POLY).

Source files
------------

// File: rtl/karatsuba_gf2_mult_seq.sv
// Multi-cycle Karatsuba carry-less multiplier over GF(2)[x].
// One P x P schoolbook sub-multiplier is reused for the three partial
// products (LL, HH, MID). The products are then combined into the full
// (2M-1)-bit product, which can optionally be reduced modulo POLY.
// Operands and the result use valid/ready handshakes.
module karatsuba_gf2_mult_seq #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11B
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   in_a,
  input  logic [M-1:0]   in_b,
  input  logic           in_reduce,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-2:0] out_data
);

  // Half width. For odd M the high half is zero-extended to P bits.
  localparam int P  = (M + 1) / 2;
  // Width of one partial product.
  localparam int CW = 2 * P - 1;
  // Width of the full product.
  localparam int RW = 2 * M - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    HH   = 3'd2,
    MID  = 3'd3,
    COMB = 3'd4,
    RED  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t          state;
  logic [M-1:0]    a_reg;
  logic [M-1:0]    b_reg;
  logic            reduce_reg;
  logic [CW-1:0]   c_ll;
  logic [CW-1:0]   c_hh;
  logic [CW-1:0]   c_m;
  logic [RW-1:0]   raw_reg;

  logic [P-1:0]    a_lo, a_hi, b_lo, b_hi;
  logic [P-1:0]    sub_x, sub_y;
  logic [CW-1:0]   sub_prod;
  logic [RW-1:0]   raw_comb;
  logic [RW-1:0]   red_comb;

  // Schoolbook carry-less product of two P-bit polynomials.
  function automatic logic [CW-1:0] clmul(input logic [P-1:0] x,
                                          input logic [P-1:0] y);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < P; i++) begin
      if (y[i]) r = r ^ (CW'(x) << i);
    end
    return r;
  endfunction

  // Split the latched operands and steer one operand pair into the shared sub-multiplier.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // that no path leaves it unassigned and no latch is inferred.
    a_lo  = a_reg[P-1:0];
    b_lo  = b_reg[P-1:0];
    a_hi  = P'(a_reg >> P);
    b_hi  = P'(b_reg >> P);
    sub_x = a_lo;
    sub_y = b_lo;
    case (state)
      HH: begin
        sub_x = a_hi;
        sub_y = b_hi;
      end
      MID: begin
        sub_x = a_lo ^ a_hi;
        sub_y = b_lo ^ b_hi;
      end
      default: ;
    endcase
    sub_prod = clmul(sub_x, sub_y);
  end

  // Karatsuba recombination. For legal inputs, the bits dropped by truncation are always zero.
  always_comb begin
    raw_comb = (RW'(c_hh) << (2 * P))
             ^ (RW'(c_m ^ c_hh ^ c_ll) << P)
             ^ RW'(c_ll);
  end

  // Single-pass reduction mod POLY, scanning from the top bit down, or pass-through.
  always_comb begin
    red_comb = raw_reg;
    if (reduce_reg) begin
      for (int i = 2 * M - 2; i >= M; i--) begin
        if (red_comb[i]) red_comb = red_comb ^ (RW'(POLY) << (i - M));
      end
    end
  end

  // Control FSM with registered handshake outputs, plus the datapath registers it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      reduce_reg <= 1'b0;
      c_ll       <= '0;
      c_hh       <= '0;
      c_m        <= '0;
      raw_reg    <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            reduce_reg <= in_reduce;
            in_ready   <= 1'b0;
            state      <= LL;
          end
        end
        LL: begin
          c_ll  <= sub_prod;
          state <= HH;
        end
        HH: begin
          c_hh  <= sub_prod;
          state <= MID;
        end
        MID: begin
          c_m   <= sub_prod;
          state <= COMB;
        end
        COMB: begin
          raw_reg <= raw_comb;
          state   <= RED;
        end
        RED: begin
          out_data  <= red_comb;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_gf2_mult_seq.sv
// Self-checking bench for karatsuba_gf2_mult_seq.
// Instance u8 uses M=8 with POLY 0x11B. Instance u5 uses M=5 (odd split) with POLY 0x25.
module tb_karatsuba_gf2_mult_seq;

  logic clk;
  logic rst_n;

  // M=8 instance signals
  logic        in_valid8, in_ready8, in_reduce8, out_valid8, out_ready8;
  logic [7:0]  in_a8, in_b8;
  logic [14:0] out_data8;

  // M=5 instance signals
  logic        in_valid5, in_ready5, in_reduce5, out_valid5, out_ready5;
  logic [4:0]  in_a5, in_b5;
  logic [8:0]  out_data5;

  int checks;
  int failures;

  karatsuba_gf2_mult_seq #(.M(8), .POLY(9'h11B)) u8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .in_b      (in_b8),
    .in_reduce (in_reduce8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8)
  );

  karatsuba_gf2_mult_seq #(.M(5), .POLY(6'h25)) u5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in_a      (in_a5),
    .in_b      (in_b5),
    .in_reduce (in_reduce5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_data  (out_data5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        red;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [127:0] actual,
                       input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Plain shift/XOR reference: bitwise product, then top-down remainder.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input int m, input logic [64:0] poly,
                                           input logic red);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < m; i++)
      if (b[i]) p = p ^ ({64'b0, a} << i);
    if (red)
      for (int i = 2 * m - 2; i >= m; i--)
        if (p[i]) p = p ^ ({63'b0, poly} << (i - m));
    return p;
  endfunction

  // One full transaction on the M=8 instance. The operands are scrambled right
  // after the handshake. lat counts edges from the handshake edge to out_valid.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic red,
                      input int stall, output logic [14:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready8 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    in_a8 = a; in_b8 = b; in_reduce8 = red; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_a8 = ~a; in_b8 = ~b; in_reduce8 = ~red;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid8) check("timeout8", 0, 1);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    res = out_data8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  // One full transaction on the M=5 instance.
  task automatic run5(input logic [4:0] a, input logic [4:0] b, input logic red,
                      input int stall, output logic [8:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready5 && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    in_a5 = a; in_b5 = b; in_reduce5 = red; in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_valid5 = 1'b0; in_a5 = ~a; in_b5 = ~b; in_reduce5 = ~red;
    lat = 1;
    while (!out_valid5 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid5) check("timeout5", 0, 1);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    res = out_data5;
    out_ready5 = 1'b1;
    @(posedge clk); #1;
    out_ready5 = 1'b0;
  endtask

  initial begin
    logic [14:0] res8;
    logic [14:0] held;
    logic [8:0]  res5;
    int          lat;

    checks = 0;
    failures = 0;

    vecs[0] = '{8'h57, 8'h83, 1'b0, 15'h2B79};
    vecs[1] = '{8'h57, 8'h83, 1'b1, 15'h00C1};
    vecs[2] = '{8'h01, 8'hAB, 1'b1, 15'h00AB};
    vecs[3] = '{8'h00, 8'hAB, 1'b1, 15'h0000};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 15'h5555};
    vecs[5] = '{8'h02, 8'h80, 1'b0, 15'h0100};
    vecs[6] = '{8'h02, 8'h80, 1'b1, 15'h001B};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 15'h4000};
    vecs[8] = '{8'h57, 8'h83, 1'b0, 15'h2B79};

    rst_n = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_reduce8 = 1'b0; out_ready8 = 1'b0;
    in_valid5 = 1'b0; in_a5 = '0; in_b5 = '0; in_reduce5 = 1'b0; out_ready5 = 1'b0;
    #12;
    check("rst_in_ready8", in_ready8, 1);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_out_data8", out_data8, 0);
    check("rst_in_ready5", in_ready5, 1);
    check("rst_out_valid5", out_valid5, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table on M=8: value, fixed latency, and release of the output.
    for (int i = 0; i < 9; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].red, i % 3, res8, lat);
      check($sformatf("vec%0d_data", i), res8, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 6);
      check($sformatf("vec%0d_in_ready_after", i), in_ready8, 1);
      check($sformatf("vec%0d_out_valid_after", i), out_valid8, 0);
    end

    // Odd split: M=5, P=3.
    run5(5'h1F, 5'h1F, 1'b0, 0, res5, lat);
    check("m5_1f_1f_raw", res5, 9'h155);
    check("m5_lat", lat, 6);
    run5(5'h1F, 5'h1F, 1'b1, 2, res5, lat);
    check("m5_1f_1f_red", res5, ref_mul(64'h1F, 64'h1F, 5, 65'h25, 1'b1));

    // Backpressure: hold the result for 10 cycles while a competing request is presented.
    in_a8 = 8'h57; in_b8 = 8'h83; in_reduce8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_a8 = 8'hFF; in_b8 = 8'hFF; in_reduce8 = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!out_valid8 && guard < 20) begin
        @(posedge clk); #1; guard++;
      end
    end
    check("bp_valid", out_valid8, 1);
    held = out_data8;
    check("bp_data", held, 15'h00C1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", c), out_data8, held);
      check($sformatf("bp_in_ready%0d", c), in_ready8, 0);
      check($sformatf("bp_out_valid%0d", c), out_valid8, 1);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("bp_release_in_ready", in_ready8, 1);
    check("bp_release_out_valid", out_valid8, 0);
    run8(8'h01, 8'hAB, 1'b1, 0, res8, lat);
    check("bp_second_data", res8, 15'h00AB);
    check("bp_second_lat", lat, 6);

    // Load a nonzero result so that the reset clearing out_data is observable.
    run8(8'hFF, 8'hFF, 1'b0, 0, res8, lat);
    check("pre_reset_data", res8, 15'h5555);

    // Asynchronous reset while the block is in MID.
    in_a8 = 8'h57; in_b8 = 8'h83; in_reduce8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_in_ready_busy", in_ready8, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready8, 1);
    check("async_rst_out_valid", out_valid8, 0);
    check("async_rst_out_data", out_data8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (8) begin
      @(posedge clk); #1;
      check("no_partial_result", out_valid8, 0);
    end
    run8(8'h57, 8'h83, 1'b1, 0, res8, lat);
    check("post_reset_data", res8, 15'h00C1);
    check("post_reset_lat", lat, 6);

    // Random regression with stalls, checked against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic       r;
      a = 8'($urandom);
      b = 8'($urandom);
      r = 1'($urandom);
      run8(a, b, r, $urandom_range(0, 3), res8, lat);
      check("rand8", res8, ref_mul({56'b0, a}, {56'b0, b}, 8, 65'h11B, r));
    end
    for (int n = 0; n < 200; n++) begin
      logic [4:0] a;
      logic [4:0] b;
      logic       r;
      a = 5'($urandom);
      b = 5'($urandom);
      r = 1'($urandom);
      run5(a, b, r, $urandom_range(0, 3), res5, lat);
      check("rand5", res5, ref_mul({59'b0, a}, {59'b0, b}, 5, 65'h25, r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
